multicycle_adder: RTL and testbench
===================================

// Module: multicycle_adder
// PURPOSE
//  Parametrised sequential adder. Adds two WIDTH-bit operands plus carry-in over
//  WIDTH/SLICE clock cycles, SLICE bits per cycle, with a registered ripple carry.
//  Valid/ready handshake on both input and output; one operation in flight at a time.
//  Successor to the combinational half adder; slots into datapaths that trade latency for area.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=2)
//  SLICE  1  bits added per cycle; must divide WIDTH; NSLICE = WIDTH/SLICE
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  input_A    in   WIDTH  operand A
//  input_B    in   WIDTH  operand B
//  carry_in   in   1      carry into bit 0
//  out_valid  out  1      sum/carry valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result bits
//  carry      out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, sum=0, carry=0, out_valid=0, slice counter=0,
//    in_ready=1 after release. Reset mid-RUN/DONE aborts; no partial result is kept.
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready, capture input_A, input_B, carry_in into
//    operand/carry registers, clear counter, go RUN.
//  - RUN: in_ready=0. Each cycle add slice[cnt] of A and B plus the carry register; write
//    the SLICE-bit result into the sum register at bits [cnt*SLICE +: SLICE]; update the
//    carry register; cnt++. After slice NSLICE-1, latch the final carry into carry, go DONE.
//  - Latency: out_valid rises exactly NSLICE cycles after the accepting edge.
//  - DONE: out_valid=1; sum/carry held stable until out_ready=1 (any backpressure length).
//    On out_valid&&out_ready, go IDLE; in_ready=1 on the next cycle (no same-cycle reissue).
//  - in_valid outside IDLE is ignored; inputs may change freely after capture.
//  - sum/carry retain the last result after handshake until the next completion overwrites them.
//  - Arithmetic: modulo 2^WIDTH; carry = bit WIDTH of A+B+carry_in. Slice carries never
//    cross slice boundaries except through the carry register.
//  - Counter width is $clog2(NSLICE) (minimum 1); wraps to 0 on leaving RUN.
// CONFIGURATION
//  ADDSUB_MODE_EN defined: extra input port `sub` (1 bit), sampled at capture.
//    sub=1: B operand inverted and carry_in forced to 1 (A-B); carry=1 means no borrow.
//    sub=0: identical to the plain adder.
//  ADDSUB_MODE_EN undefined: no `sub` port; adder only; carry_in always honoured.
// STRUCTURE
//  Shared package adder_pkg: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2),
//  parameter sanity checks (WIDTH % SLICE == 0).
//  Sub-module adder_slice: combinational SLICE-bit ripple adder (a, b, cin -> s, cout),
//  built from full-adder cells; instantiated once inside multicycle_adder.
// TESTING
//  1. WIDTH=8,SLICE=1: A=0x0F,B=0x01,cin=0 -> out_valid 8 cycles after accept, sum=0x10, carry=0.
//  2. WIDTH=8,SLICE=1: A=0xFF,B=0x01,cin=0 -> sum=0x00, carry=1.
//  3. WIDTH=8,SLICE=4: A=0xAA,B=0x55,cin=1 -> out_valid after 2 cycles, sum=0x00, carry=1.
//  4. Hold out_ready=0 for 5 cycles in DONE, pulse in_valid -> sum/carry stable, in_ready=0,
//     pulse ignored; out_ready=1 -> in_ready=1 next cycle.
//  5. Assert rst_n=0 three cycles into RUN -> out_valid=0, sum=0, carry=0 immediately;
//     in_ready=1 after release; next op A=0x03,B=0x04 -> sum=0x07.
//  6. ADDSUB_MODE_EN, sub=1: A=0x05,B=0x07 -> sum=0xFE, carry=0; A=0x07,B=0x05 -> sum=0x02, carry=1.

Source files
------------

// File: rtl/multicycle_adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the multicycle adder slice:
//     - state_t     : controller state encodings (ST_IDLE/ST_RUN/ST_DONE)
//     - params_ok() : parameter sanity check (WIDTH >= 2, SLICE divides WIDTH)
//     - cnt_width() : slice counter width, never less than one bit
//   No ports; imported by multicycle_adder.
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic bit params_ok(input int width, input int slice);
        return (width >= 2) && (slice >= 1) && (slice <= width) && ((width % slice) == 0);
    endfunction

    // A single-slice configuration still needs a one-bit counter register.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// -----------------------------------------------------------------------------
// multicycle_adder_if
//   Handshake bundle between a producer/consumer (master) and the
//   multicycle adder (slave).
//     in_valid / in_ready   : operand handshake
//     input_A, input_B      : WIDTH-bit operands
//     carry_in              : carry into bit 0
//     sub                   : subtract select (only when ADDSUB_MODE_EN defined)
//     out_valid / out_ready : result handshake
//     sum, carry            : WIDTH-bit result and carry out of the top bit
//   Macro: ADDSUB_MODE_EN adds the `sub` signal.
// -----------------------------------------------------------------------------
interface multicycle_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_A;
    logic [WIDTH-1:0] input_B;
    logic             carry_in;
`ifdef ADDSUB_MODE_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;

`ifdef ADDSUB_MODE_EN
    modport master (
        output in_valid, input_A, input_B, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry
    );
    modport slave (
        input  in_valid, input_A, input_B, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry
    );
`else
    modport master (
        output in_valid, input_A, input_B, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry
    );
    modport slave (
        input  in_valid, input_A, input_B, carry_in, out_ready,
        output in_ready, out_valid, sum, carry
    );
`endif

endinterface

// File: rtl/multicycle_adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Combinational SLICE-bit ripple-carry adder built from full-adder cells.
//     a, b : SLICE-bit addends
//     cin  : carry into bit 0
//     s    : SLICE-bit sum
//     cout : carry out of bit SLICE-1
// -----------------------------------------------------------------------------
module adder_slice #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        logic p;
        assign p        = a[i] ^ b[i];
        assign s[i]     = p ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (p & c[i]);
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//   Sequential adder: sums two WIDTH-bit operands plus a carry over
//   NSLICE = WIDTH/SLICE cycles, SLICE bits per cycle, carrying between
//   slices through a register. One operation in flight at a time.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : multicycle_adder_if slave modport (operand/result handshakes)
//   Parameters: WIDTH (>= 2), SLICE (must divide WIDTH).
//   Macro: ADDSUB_MODE_EN enables bus.sub; when set at capture, B is
//   inverted and the carry forced to 1, giving A-B (carry=1 means no borrow).
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | in_ready=1, waiting for in_valid; operands captured on accept
//   ST_RUN  | one slice added per cycle, sum written at [cnt*SLICE +: SLICE]
//   ST_DONE | out_valid=1, result held until out_ready
// -----------------------------------------------------------------------------
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_adder_if.slave    bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSLICE - 1);

    if (!params_ok(WIDTH, SLICE)) begin : g_param_err
        $error("multicycle_adder: WIDTH must be >= 2 and a multiple of SLICE");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             c_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] s_sl;
    logic             cout_sl;
    int               base;

    // Operand B and carry as seen at capture; subtract mode folds the
    // two's-complement negation into the same adder.
    logic [WIDTH-1:0] b_cap;
    logic             c_cap;

`ifdef ADDSUB_MODE_EN
    assign b_cap = bus.sub ? ~bus.input_B : bus.input_B;
    assign c_cap = bus.sub ? 1'b1 : bus.carry_in;
`else
    assign b_cap = bus.input_B;
    assign c_cap = bus.carry_in;
`endif

    always_comb begin
        base = int'(cnt) * SLICE;
        a_sl = a_reg[base +: SLICE];
        b_sl = b_reg[base +: SLICE];
    end

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (c_reg),
        .s    (s_sl),
        .cout (cout_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            c_reg         <= 1'b0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        a_reg        <= bus.input_A;
                        b_reg        <= b_cap;
                        c_reg        <= c_cap;
                        cnt          <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    sum_reg[base +: SLICE] <= s_sl;
                    c_reg                  <= cout_sl;
                    if (cnt == CNT_LAST) begin
                        carry_reg     <= cout_sl;
                        out_valid_reg <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DONE: begin
                    // in_ready only returns on the following cycle, so a new
                    // operand can never be taken on the result handshake edge.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                default: begin
                    cnt           <= '0;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.carry     = carry_reg;

endmodule

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
//   Two adders share clock and reset: dut1 (WIDTH=8, SLICE=1) and
//   dut4 (WIDTH=8, SLICE=4). Expected {carry,sum} values are queued on
//   operand accept and popped when the adder presents its result.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multicycle_adder_if #(.WIDTH(W)) bus1 ();
    multicycle_adder_if #(.WIDTH(W)) bus4 ();

    multicycle_adder #(.WIDTH(W), .SLICE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    multicycle_adder #(.WIDTH(W), .SLICE(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    logic [W-1:0] a_drv   = '0;
    logic [W-1:0] b_drv   = '0;
    logic         cin_drv = 1'b0;
    logic [1:0]   vld     = '0;
    logic [1:0]   ordy    = '0;
`ifdef ADDSUB_MODE_EN
    logic         sub_drv = 1'b0;
    assign bus1.sub = sub_drv;
    assign bus4.sub = sub_drv;
`endif

    assign bus1.input_A   = a_drv;
    assign bus1.input_B   = b_drv;
    assign bus1.carry_in  = cin_drv;
    assign bus1.in_valid  = vld[0];
    assign bus1.out_ready = ordy[0];
    assign bus4.input_A   = a_drv;
    assign bus4.input_B   = b_drv;
    assign bus4.carry_in  = cin_drv;
    assign bus4.in_valid  = vld[1];
    assign bus4.out_ready = ordy[1];

    logic [1:0]   ov;
    logic [1:0]   ir;
    logic [1:0]   cy;
    logic [W-1:0] sm [2];

    assign ov[0] = bus1.out_valid;
    assign ov[1] = bus4.out_valid;
    assign ir[0] = bus1.in_ready;
    assign ir[1] = bus4.in_ready;
    assign cy[0] = bus1.carry;
    assign cy[1] = bus4.carry;
    assign sm[0] = bus1.sum;
    assign sm[1] = bus4.sum;

    logic [W:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int nslice(input int sel);
        return (sel == 0) ? 8 : 2;
    endfunction

    // Runs one operation on DUT `sel`; called 1 time unit after a clock edge.
    // hold > 0 keeps out_ready low for that many cycles in DONE; pulse
    // raises in_valid with fresh operands during the hold.
    task automatic do_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sb, input int hold, input bit pulse);
        logic [W:0] e;
        logic [W:0] got;
        int cyc;
        check("in_ready_idle", 32'(ir[sel]), 32'd1);
        a_drv   = a;
        b_drv   = b;
        cin_drv = cin;
`ifdef ADDSUB_MODE_EN
        sub_drv = sb;
`endif
        vld[sel]  = 1'b1;
        ordy[sel] = (hold == 0);
        e = {1'b0, a} + {1'b0, (sb ? ~b : b)} + {{W{1'b0}}, (sb ? 1'b1 : cin)};
        exp_q.push_back(e);
        tick;
        vld[sel] = 1'b0;
        a_drv    = W'($urandom);
        b_drv    = W'($urandom);
        cin_drv  = 1'($urandom);
        check("in_ready_busy", 32'(ir[sel]), 32'd0);
        cyc = 0;
        while (!ov[sel] && cyc < 64) begin
            tick;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(nslice(sel)));
        got = {cy[sel], sm[sel]};
        check("result", 32'(got), 32'(exp_q.pop_front()));
        for (int i = 0; i < hold; i++) begin
            if (pulse && i == 1) begin
                vld[sel] = 1'b1;
                a_drv    = W'($urandom);
                b_drv    = W'($urandom);
            end
            tick;
            vld[sel] = 1'b0;
            check("hold_valid", 32'(ov[sel]), 32'd1);
            check("hold_in_ready", 32'(ir[sel]), 32'd0);
            check("hold_result", 32'({cy[sel], sm[sel]}), 32'(e));
        end
        ordy[sel] = 1'b1;
        tick;
        check("valid_drop", 32'(ov[sel]), 32'd0);
        check("in_ready_next", 32'(ir[sel]), 32'd1);
        check("result_retained", 32'({cy[sel], sm[sel]}), 32'(e));
    endtask

    initial begin
        #2;
        check("rst_valid1", 32'(ov[0]), 32'd0);
        check("rst_sum1", 32'(sm[0]), 32'd0);
        check("rst_carry1", 32'(cy[0]), 32'd0);
        check("rst_valid4", 32'(ov[1]), 32'd0);
        check("rst_sum4", 32'(sm[1]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("rel_in_ready1", 32'(ir[0]), 32'd1);
        check("rel_in_ready4", 32'(ir[1]), 32'd1);

        do_op(0, 8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        do_op(1, 8'hAA, 8'h55, 1'b1, 1'b0, 0, 1'b0);
        do_op(1, 8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_op(0, W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0, 1'b0);
            do_op(1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0, 1'b0);
        end

        // Backpressure with an ignored in_valid pulse, on both slicings.
        do_op(0, 8'h3C, 8'hC4, 1'b0, 1'b0, 5, 1'b1);
        tick;
        check("no_reissue1", 32'(ov[0]), 32'd0);
        do_op(1, 8'h81, 8'h7F, 1'b1, 1'b0, 5, 1'b1);
        tick;
        check("no_reissue4", 32'(ov[1]), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort three cycles into RUN; partial sum is nonzero at that point.
        a_drv   = 8'hFF;
        b_drv   = 8'h00;
        cin_drv = 1'b0;
        vld[0]  = 1'b1;
        tick;
        vld[0] = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(ov[0]), 32'd0);
        check("abort_sum", 32'(sm[0]), 32'd0);
        check("abort_carry", 32'(cy[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        check("abort_in_ready", 32'(ir[0]), 32'd1);
        do_op(0, 8'h03, 8'h04, 1'b0, 1'b0, 0, 1'b0);

`ifdef ADDSUB_MODE_EN
        do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0);
        do_op(0, 8'h07, 8'h05, 1'b0, 1'b1, 0, 1'b0);
        do_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0);
        do_op(0, 8'h07, 8'h05, 1'b1, 1'b0, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
